// File: rtl/alu_seq.sv
// Sequential 16-op ALU with valid/ready on both sides and an iterative restoring divider.
// Results and flags are registered; only i_in_ready's counterpart o_in_ready is combinational.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [3:0]           i_sel,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_flag_zero,
  output logic                 o_flag_carry,
  output logic                 o_flag_dbz
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e             r_state;
  logic [2*WIDTH-1:0] r_result;
  logic               r_out_valid;
  logic               r_flag_zero;
  logic               r_flag_carry;
  logic               r_flag_dbz;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div_b;
  logic [CntW-1:0]    r_cnt;

  logic               w_accept;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_res;
  logic               w_carry;
  logic               w_dbz;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [2*WIDTH-1:0] w_div_res;

  assign o_in_ready  = (r_state == StIdle) | ((r_state == StDone) & i_out_ready);
  assign w_accept    = i_in_valid & o_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_flag_zero  = r_flag_zero;
  assign o_flag_carry = r_flag_carry;
  assign o_flag_dbz   = r_flag_dbz;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub  = {1'b0, i_a} - {1'b0, i_b};
  assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_dbz   = 1'b0;
    case (i_sel)
      4'd0:  begin w_res[WIDTH:0] = w_sum; w_carry = w_sum[WIDTH]; end
      4'd1:  begin w_res[WIDTH-1:0] = w_sub[WIDTH-1:0]; w_carry = w_sub[WIDTH]; end
      4'd2:  w_res = w_prod;
      // Only reaches the result path when b == 0; nonzero divisors go to StDiv.
      4'd3:  begin w_res = {i_a, {WIDTH{1'b1}}}; w_dbz = 1'b1; end
      4'd4:  begin w_res[WIDTH:0] = {i_a, 1'b0}; w_carry = i_a[WIDTH-1]; end
      4'd5:  begin w_res[WIDTH-1:0] = i_a >> 1; w_carry = i_a[0]; end
      4'd6:  w_res[WIDTH-1:0] = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
      4'd7:  w_res[WIDTH-1:0] = {i_a[0], i_a[WIDTH-1:1]};
      4'd8:  w_res[WIDTH-1:0] = i_a & i_b;
      4'd9:  w_res[WIDTH-1:0] = i_a | i_b;
      4'd10: w_res[WIDTH-1:0] = i_a ^ i_b;
      4'd11: w_res[WIDTH-1:0] = ~(i_a | i_b);
      4'd12: w_res[WIDTH-1:0] = ~(i_a & i_b);
      4'd13: w_res[WIDTH-1:0] = ~(i_a ^ i_b);
      4'd14: w_res[0] = (i_a > i_b);
      4'd15: w_res[0] = (i_a == i_b);
      default: w_res = '0;
    endcase
  end

  // Restoring step: the partial remainder is always < b, so the difference fits in WIDTH bits.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div_b});
  assign w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_div_b) : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_div_res = {r_rem, r_quo};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_result     <= '0;
      r_out_valid  <= 1'b0;
      r_flag_zero  <= 1'b0;
      r_flag_carry <= 1'b0;
      r_flag_dbz   <= 1'b0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_div_b      <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        StDiv: begin
          if (r_cnt == CntW'(WIDTH)) begin
            r_result     <= w_div_res;
            r_flag_zero  <= (w_div_res == '0);
            r_flag_carry <= 1'b0;
            r_flag_dbz   <= 1'b0;
            r_out_valid  <= 1'b1;
            r_state      <= StDone;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            if ((i_sel == 4'd3) && (i_b != '0)) begin
              r_rem       <= '0;
              r_quo       <= i_a;
              r_div_b     <= i_b;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_state     <= StDiv;
            end else begin
              r_result     <= w_res;
              r_flag_zero  <= (w_res == '0);
              r_flag_carry <= w_carry;
              r_flag_dbz   <= w_dbz;
              r_out_valid  <= 1'b1;
              r_state      <= StDone;
            end
          end else if ((r_state == StDone) && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised successor to the team's 8-bit combinational ALU, with the same 16-operation `sel` encoding. It takes operands through a valid/ready input handshake and registers the result and status flags behind a valid/ready output handshake. Division is iterative, one quotient bit per cycle, and returns both quotient and remainder. It sits between an operand-issuing controller and a result consumer, and tolerates back-pressure on either side.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be at least 2. The result is 2*WIDTH bits.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operand/opcode present.
- `in_ready` out 1: block can accept; `in_valid & in_ready` is an accept.
- `sel` in 4: opcode, sampled on accept.
- `a` in WIDTH: operand A, sampled on accept.
- `b` in WIDTH: operand B, sampled on accept.
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer takes result; `out_valid & out_ready` is a handshake.
- `result` out 2*WIDTH: registered result.
- `flag_zero` out 1: `result` == 0.
- `flag_carry` out 1: carry/borrow/shift-out, depending on opcode.
- `flag_dbz` out 1: divide by zero.

## Operation
- States: IDLE, DIV, DONE. All outputs are registered; only `in_ready` is combinational.
- `in_ready` = (state == IDLE) | (state == DONE & `out_ready`).
- **Accept, non-divide opcode:** compute in the accept cycle, load `result`/flags, go to DONE.
- **Accept, `sel`=3 with `b`≠0:** latch operands, go to DIV with iteration count 0.
- **Accept, `sel`=3 with `b`=0:** go directly to DONE.
  - `result` = {`a`, all-ones WIDTH}; `flag_dbz`=1.
- **DONE:**
  - Hold `result`/flags stable while `out_ready`=0.
  - On handshake without a new accept, go to IDLE and clear `out_valid`.
  - On handshake with a simultaneous accept, process the new operation as if from IDLE.
- **Opcodes.** In every case, bits not listed are zero and `flag_carry`=0 unless stated.
  - 0 add: `result`[WIDTH:0] = a+b; `flag_carry` = bit WIDTH.
  - 1 sub: `result`[WIDTH-1:0] = (a−b) mod 2^WIDTH; `flag_carry` = borrow (a<b).
  - 2 mul: `result` = a*b, full 2*WIDTH bits, unsigned.
  - 3 div: `result`[WIDTH-1:0] = quotient, `result`[2*WIDTH-1:WIDTH] = remainder, unsigned.
  - 4 shl: `result`[WIDTH:0] = a<<1; `flag_carry` = a[WIDTH-1].
  - 5 shr: `result` = a>>1; `flag_carry` = a[0].
  - 6 rol: {a[WIDTH-2:0], a[WIDTH-1]}.
  - 7 ror: {a[0], a[WIDTH-1:1]}.
  - 8 and, 9 or, 10 xor: bitwise on WIDTH bits.
  - 11 nor, 12 nand, 13 xnor: bitwise on WIDTH bits, inverted over WIDTH bits only; upper WIDTH bits stay zero.
  - 14 gt: `result` = (a>b) ? 1 : 0, unsigned.
  - 15 eq: `result` = (a==b) ? 1 : 0.
- **Divide algorithm:** restoring, with a WIDTH+1-bit partial remainder and a WIDTH-bit quotient shift register.
  - Each DIV cycle: shift {rem, quo} left by one and trial-subtract b.
  - If non-negative, keep the difference and set the quotient LSB.
  - After WIDTH iterations, load `result`, go to DONE.
- `flag_zero` is computed from the final 2*WIDTH-bit `result` for every opcode, divide included.
- `flag_dbz` is 1 only for a divide with b=0, otherwise 0.

## Timing
- **Reset:** while `rst`=1 at an edge, the next state is IDLE and the outputs are:
  - `out_valid`=0, `result`=0;
  - `flag_zero`=0, `flag_carry`=0, `flag_dbz`=0.
- `in_ready`=1 in the first cycle after `rst` deasserts.
- Reset mid-division aborts the division; no result is produced.
- **Latency, non-divide and divide-by-zero:** accept at edge N, `out_valid`=1 from edge N+1.
- **Latency, divide with b≠0:** accept at edge N, `out_valid`=1 from edge N+WIDTH+1.
- **Throughput:** one non-divide operation per cycle when `out_ready` is held high.
- `in_ready`=0 throughout DIV, and in DONE while `out_ready`=0.
- `a`, `b`, `sel` are ignored except in the accept cycle. Changing them during DIV has no effect.
- `in_valid` with `in_ready`=0 is not an accept. The source must hold its values.
- `out_valid` never drops without a handshake, except on reset.

## Test plan
- **Add with carry, WIDTH=8:** a=0xFF, b=0x01, sel=0 → one cycle later `result`=0x0100, `flag_carry`=1, `flag_zero`=0.
- **Divide, WIDTH=8:** a=200, b=7, sel=3 → `out_valid` exactly 9 cycles after accept; `result`=0x041C (rem 4, quo 28); `in_ready`=0 during those cycles.
- **Divide by zero:** a=0x5A, b=0, sel=3 → one cycle later `result`=0x5AFF, `flag_dbz`=1; then a=0, b=1, sel=3 → `result`=0, `flag_zero`=1, `flag_dbz`=0.
- **Back-pressure and streaming:** issue sub a=3, b=5 with `out_ready`=0 for 5 cycles.
  - `result`=0x00FE, `flag_carry`=1 held stable; `in_ready`=0.
  - Then raise `out_ready` and stream xor, nand, eq back-to-back → one result per cycle, in order.
- **Reset mid-division:** assert `rst` 4 cycles into a divide → next cycle all outputs 0 and `in_ready`=1; a fresh add of 2+3 then yields `result`=5.
- **WIDTH=16:** mul 0xFFFF*0xFFFF → `result`=0xFFFE0001; rol a=0x8001 → 0x0003; divide 0xFFFF/0x0003 → quotient 0x5555, remainder 0, latency 17 cycles.
